// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and word-select helper for the SHA-256 digest path.
package sha256_pkg;

    localparam int WORD_W    = 64;
    localparam int DIGEST_W  = 256;
    localparam int NUM_WORDS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Word 0 is the most significant 64 bits (H0H1), word 3 the least significant (H6H7).
    function automatic logic [WORD_W-1:0] word_sel(input logic [DIGEST_W-1:0] digest,
                                                   input logic [1:0]          idx);
        return digest[DIGEST_W-1-WORD_W*int'(idx) -: WORD_W];
    endfunction

endpackage

// File: rtl/sha256_digest_reader.sv
// Serialises a captured 256-bit digest into four 64-bit words over a valid/ready stream,
// flagging any digest pulse that arrives while a previous digest is still draining.
module sha256_digest_reader
    import sha256_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [DIGEST_W-1:0] digest_i,
    input  logic                digest_valid_i,
    input  logic                ready_i,
    output logic [WORD_W-1:0]   data_o,
    output logic                valid_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                overrun_o
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

    state_e              state_q,   state_d;
    logic [1:0]          cnt_q,     cnt_d;
    logic [DIGEST_W-1:0] shadow_q,  shadow_d;
    logic [WORD_W-1:0]   data_q,    data_d;
    logic                overrun_q, overrun_d;
    logic                xfer;
    logic                final_xfer;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        overrun_d  = overrun_q;
        xfer       = (state_q == ST_SEND) && ready_i;
        final_xfer = xfer && (cnt_q == LAST_IDX);

        case (state_q)
            ST_IDLE: begin
                if (digest_valid_i) begin
                    shadow_d = digest_i;
                    cnt_d    = 2'd0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    cnt_d = cnt_q + 2'd1;
                end
                if (final_xfer) begin
                    // A digest arriving on the last handshake chains straight on with no bubble.
                    if (digest_valid_i) begin
                        shadow_d = digest_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (digest_valid_i) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output word is registered from next state so IDLE keeps the last word on data_o.
        data_d = (state_d == ST_SEND) ? word_sel(shadow_d, cnt_d) : data_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            shadow_q  <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = (state_q == ST_SEND);
    assign busy_o    = (state_q == ST_SEND);
    assign last_o    = (state_q == ST_SEND) && (cnt_q == LAST_IDX);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_sha256_digest_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] digest = '0;
    logic         digest_valid = 1'b0;
    logic         ready = 1'b0;
    logic [63:0]  data;
    logic         valid, last, busy, overrun;

    int errors = 0;
    int checks = 0;

    // Model: the words still to be sent, the last word presented, and the sticky drop flag.
    logic [63:0] pend_q[$];
    logic [63:0] m_data = '0;
    logic        m_ovr  = 1'b0;

    localparam logic [255:0] DIG_BYTES = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [255:0] DIG_AA    = {32{8'hAA}};

    always #5 clk = ~clk;

    sha256_digest_reader dut (
        .CLK            (clk),
        .RST            (rst_n),
        .digest_i       (digest),
        .digest_valid_i (digest_valid),
        .ready_i        (ready),
        .data_o         (data),
        .valid_o        (valid),
        .last_o         (last),
        .busy_o         (busy),
        .overrun_o      (overrun)
    );

    // Apply inputs for one clock edge, advance the model, then settle 1 time unit past the edge.
    task automatic step(input logic r, input logic dv, input logic rdy, input logic [255:0] dg);
        int  n;
        bit  hs;
        rst_n = r; digest_valid = dv; ready = rdy; digest = dg;
        @(posedge clk);
        if (!r) begin
            pend_q.delete();
            m_ovr  = 1'b0;
            m_data = '0;
        end else begin
            n  = pend_q.size();
            hs = (n > 0) && rdy;
            if (hs) void'(pend_q.pop_front());
            if (dv) begin
                if (n == 0 || (hs && n == 1)) begin
                    for (int i = 0; i < 4; i++) pend_q.push_back(dg[255-64*i -: 64]);
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        if (pend_q.size() > 0) m_data = pend_q[0];
        #1;
        digest_valid = 1'b0;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, 1'b1, DIG_AA);
        checks++;
        if ({valid, last, busy, overrun} !== 4'b0000 || data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b o=%b d=%h, want all zero", valid, last, busy, overrun, data);
        end
        step(1'b1, 1'b0, 1'b1, '0);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got valid=%b, want 0", valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_drain;
        logic [63:0] w [4] = '{64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                               64'h1011121314151617, 64'h18191A1B1C1D1E1F};
        step(1'b1, 1'b1, 1'b1, DIG_BYTES);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data !== w[i] || valid !== 1'b1 || busy !== 1'b1 || last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_word%0d: got d=%h v=%b b=%b l=%b, want d=%h v=1 b=1 l=%b", i, data, valid, busy, last, w[i], i == 3);
            end
            step(1'b1, 1'b0, 1'b1, '0);
        end
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || data !== w[3]) begin
            errors++;
            $display("FAIL basic_idle: got v=%b b=%b l=%b d=%h, want 0 0 0 d=%h", valid, busy, last, data, w[3]);
        end
        $display("test_basic_drain done");
    endtask

    task automatic test_backpressure;
        step(1'b1, 1'b1, 1'b0, DIG_BYTES);
        step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            checks++;
            if (data !== 64'h08090A0B0C0D0E0F || valid !== 1'b1 || last !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: got d=%h v=%b l=%b, want d=08090a0b0c0d0e0f v=1 l=0", i, data, valid, last);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);
        checks++;
        if (valid !== 1'b0 || data !== 64'h18191A1B1C1D1E1F) begin
            errors++;
            $display("FAIL stall_drain: got v=%b d=%h, want v=0 d=18191a1b1c1d1e1f", valid, data);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back;
        step(1'b1, 1'b1, 1'b1, DIG_BYTES);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);
        checks++;
        if (last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last: got last=%b, want 1", last);
        end
        step(1'b1, 1'b1, 1'b1, DIG_AA);
        checks++;
        if (data !== 64'hAAAAAAAAAAAAAAAA || valid !== 1'b1 || busy !== 1'b1 || overrun !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got d=%h v=%b b=%b o=%b l=%b, want aaaaaaaaaaaaaaaa 1 1 0 0", data, valid, busy, overrun, last);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, '0);
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%b o=%b, want 0 0", valid, overrun);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_overrun;
        logic [63:0] w [4] = '{64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                               64'h1011121314151617, 64'h18191A1B1C1D1E1F};
        step(1'b1, 1'b1, 1'b1, DIG_BYTES);
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, DIG_AA);
        checks++;
        if (overrun !== 1'b1 || data !== w[1]) begin
            errors++;
            $display("FAIL overrun_set: got o=%b d=%h, want o=1 d=%h", overrun, data, w[1]);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (data !== w[i]) begin
                errors++;
                $display("FAIL overrun_word%0d: got %h, want %h", i, data, w[i]);
            end
            step(1'b1, 1'b0, 1'b1, '0);
        end
        step(1'b1, 1'b0, 1'b1, '0);
        checks++;
        if (overrun !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got o=%b v=%b, want o=1 v=0", overrun, valid);
        end
        $display("test_overrun done");
    endtask

    task automatic test_midreset;
        step(1'b1, 1'b1, 1'b1, DIG_AA);
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if ({valid, last, busy, overrun} !== 4'b0000 || data !== 64'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b l=%b b=%b o=%b d=%h, want all zero", valid, last, busy, overrun, data);
        end
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, '0);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got valid=%b, want 0", valid);
        end
        step(1'b1, 1'b1, 1'b0, DIG_BYTES);
        checks++;
        if (data !== 64'h0001020304050607 || valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart: got d=%h v=%b, want 0001020304050607 1", data, valid);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, '0);
        $display("test_midreset done");
    endtask

    task automatic test_random;
        logic [255:0] dg;
        logic         m_valid, m_last;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 8; k++) dg[32*k +: 32] = $urandom;
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0), dg);
            m_valid = (pend_q.size() > 0);
            m_last  = (pend_q.size() == 1);
            checks++;
            if (valid !== m_valid || busy !== m_valid || last !== m_last || data !== m_data || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random_cycle%0d: got v=%b b=%b l=%b o=%b d=%h, want v=%b b=%b l=%b o=%b d=%h",
                         c, valid, busy, last, overrun, data, m_valid, m_valid, m_last, m_ovr, m_data);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_digest_reader.md
SHA256_DIGEST_READER -- requirements
Module: sha256_digest_reader

Interface
REQ-001 Parameters: none; all widths come from the shared package constants WORD_W=64, DIGEST_W=256, NUM_WORDS=4.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low; sampled on the rising edge of CLK only.
REQ-004 digest_i  input  256  final hash H0..H7, H0 in bits [255:224].
REQ-005 digest_valid_i  input  1  single-cycle pulse; digest_i is valid in this cycle.
REQ-006 ready_i  input  1  downstream sink accepts data_o in this cycle.
REQ-007 data_o  output  64  current outgoing digest word.
REQ-008 valid_o  output  1  data_o holds a valid word.
REQ-009 last_o  output  1  data_o is word 3, the final word.
REQ-010 busy_o  output  1  a digest is captured and not yet fully drained.
REQ-011 overrun_o  output  1  sticky flag: a digest_valid_i pulse was dropped.

Function
REQ-012 FSM states: IDLE and SEND, defined as an enum in the package.
REQ-013 IDLE with digest_valid_i=1:
- capture digest_i into a 256-bit shadow register;
- set word counter to 0;
- go to SEND on the next edge.
REQ-014 SEND drives the following:
- valid_o=1, busy_o=1;
- data_o = shadow[255-64*cnt -: 64], so word order is H0H1, H2H3, H4H5, H6H7;
- last_o = (cnt==3).
REQ-015 Transfer occurs only when valid_o=1 and ready_i=1 in the same cycle; then cnt increments by 1.
REQ-016 With ready_i=0, data_o, last_o and cnt hold stable with no limit on stall length; valid_o never drops while in SEND.
REQ-017 Transfer with cnt==3, no digest_valid_i: go to IDLE; valid_o, last_o and busy_o are 0 from the next cycle.
REQ-018 Transfer with cnt==3 and digest_valid_i=1 in the same cycle:
- capture the new digest;
- cnt wraps to 0;
- stay in SEND, giving back-to-back output with no bubble.
REQ-019 digest_valid_i=1 in SEND, other than the case in REQ-018:
- the pulse is ignored and the shadow register is unchanged;
- overrun_o is set to 1 on the next edge.
REQ-020 overrun_o stays set until reset.
REQ-021 In IDLE: valid_o=0, last_o=0, busy_o=0; data_o is held at its last value.
REQ-022 cnt is 2 bits wide and wraps modulo 4; no other wrap path exists.
REQ-023 Latency: the first word is valid one cycle after the digest_valid_i pulse.
REQ-024 Minimum drain time is 4 cycles, with ready_i held high.

Reset
REQ-025 With RST=0 at a rising edge:
- state goes to IDLE;
- cnt=0;
- shadow=0 and data_o=0;
- valid_o, last_o, busy_o and overrun_o all 0.
REQ-026 Reset asserted mid-drain aborts the transfer; no further words are emitted after reset releases.
REQ-027 Reset has priority over every other input, including a digest_valid_i in the same cycle.

Structure
REQ-028 The shared package sha256_pkg holds:
- WORD_W, DIGEST_W and NUM_WORDS;
- the state enum for this FSM.
REQ-029 Single module, no sub-module: the shadow register, counter and FSM are kept inline (about 150 RTL lines).

Verification
REQ-030 Basic drain:
- Stimulus: digest_i=0x00010203..1C1D1E1F (bytes 00..1F), ready_i=1.
- Response: words 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121314151617, 0x18191A1B1C1D1E1F on 4 consecutive cycles, with last_o=1 only on the 4th.
REQ-031 Backpressure:
- Stimulus: ready_i=0 for 5 cycles on word 1.
- Response: data_o=0x08090A0B0C0D0E0F and valid_o=1 held stable throughout; drain completes after ready_i returns to 1.
REQ-032 Back-to-back:
- Stimulus: second digest (all bytes 0xAA) pulsed in the cycle of the last handshake.
- Response: next cycle gives data_o=0xAAAAAAAAAAAAAAAA, valid_o=1, busy_o=1, overrun_o=0.
REQ-033 Overrun:
- Stimulus: digest_valid_i pulsed while cnt==1.
- Response: overrun_o=1 from the next cycle, stays 1 after the drain; the original words are unchanged.
REQ-034 Mid-drain reset:
- Stimulus: RST=0 for 1 cycle at cnt==2.
- Response: next cycle all outputs are 0 and the state is IDLE; the next digest_valid_i restarts output at word 0.
